// File: rtl/gmii_tx_arbiter.sv
// Two-requester GMII transmit arbiter: grants round-robin, then frames the winner's
// payload with preamble/SFD, flags underruns with TX_ER and enforces the inter-packet gap.
module gmii_tx_arbiter #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_CYCLES   = 12
) (
    input  logic       GTX_CLK,
    input  logic       mr_main_reset,
    input  logic       code_sync_status,
    input  logic       transmitting,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last0,
    input  logic       last1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ready0,
    output logic       ready1,
    output logic [7:0] TXD,
    output logic       TX_EN,
    output logic       TX_ER,
    output logic       busy
);

    // state    | meaning
    // IDLE     | no owner, waiting for a request with link synced and PCS free
    // PREAMBLE | shifting out 0x55 bytes (first one was loaded on the start edge)
    // SFD      | registering the 0xD5 start-of-frame delimiter
    // DATA     | owner's bytes accepted and forwarded one cycle later
    // DRAIN    | underrun seen, owner's remaining bytes discarded up to last
    // IPG      | TX_EN held low for the gap, then the grant is released
    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA,
        DRAIN,
        IPG
    } state_t;

    localparam int CNT_MAX = (IPG_CYCLES > PREAMBLE_LEN) ? IPG_CYCLES : PREAMBLE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // PREAMBLE lasts one cycle less than the byte count; the last 0x55 is shown during SFD.
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'((PREAMBLE_LEN > 1) ? PREAMBLE_LEN - 2 : 0);
    localparam logic [CNT_W-1:0] IPG_LOAD = CNT_W'(IPG_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             start;
    logic             pick1;
    logic             sel_valid;
    logic             sel_last;
    logic [7:0]       sel_data;

    assign start     = (req0 | req1) & code_sync_status & ~transmitting;
    assign pick1     = req1 & (~req0 | ~last_grant);
    assign sel_valid = gnt1 ? valid1 : valid0;
    assign sel_last  = gnt1 ? last1 : last0;
    assign sel_data  = gnt1 ? data1 : data0;
    assign ready0    = ((state == DATA) || (state == DRAIN)) & gnt0;
    assign ready1    = ((state == DATA) || (state == DRAIN)) & gnt1;
    assign busy      = (state != IDLE);

    always_ff @(posedge GTX_CLK or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            TXD        <= 8'h00;
            TX_EN      <= 1'b0;
            TX_ER      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TXD   <= 8'h00;
                    TX_EN <= 1'b0;
                    TX_ER <= 1'b0;
                    if (start) begin
                        gnt0       <= ~pick1;
                        gnt1       <= pick1;
                        last_grant <= pick1;
                        TXD        <= 8'h55;
                        TX_EN      <= 1'b1;
                        cnt        <= PRE_LOAD;
                        state      <= (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
                    end
                end
                PREAMBLE: begin
                    TXD <= 8'h55;
                    if (cnt == '0) begin
                        state <= SFD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SFD: begin
                    TXD   <= 8'hD5;
                    state <= DATA;
                end
                DATA: begin
                    TX_EN <= 1'b1;
                    if (sel_valid) begin
                        TXD   <= sel_data;
                        TX_ER <= 1'b0;
                        if (sel_last) begin
                            cnt   <= IPG_LOAD;
                            state <= IPG;
                        end
                    end else begin
                        // underrun: poison the frame for one cycle, then swallow the rest
                        TXD   <= 8'h00;
                        TX_ER <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    TXD   <= 8'h00;
                    TX_EN <= 1'b0;
                    TX_ER <= 1'b0;
                    if (sel_valid && sel_last) begin
                        cnt   <= IPG_LOAD;
                        state <= IPG;
                    end
                end
                IPG: begin
                    TXD   <= 8'h00;
                    TX_EN <= 1'b0;
                    TX_ER <= 1'b0;
                    if (cnt == '0) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    TXD   <= 8'h00;
                    TX_EN <= 1'b0;
                    TX_ER <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: a frame-level model queues the expected GMII
// byte stream and owner per frame; a negedge monitor pops and compares.
module tb_gmii_tx_arbiter;

    localparam int PRE = 7;
    localparam int IPG = 12;

    logic       GTX_CLK;
    logic       mr_main_reset;
    logic       code_sync_status;
    logic       transmitting;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       valid0, valid1, last0, last1;
    logic       gnt0, gnt1, ready0, ready1;
    logic [7:0] TXD;
    logic       TX_EN, TX_ER, busy;

    gmii_tx_arbiter #(.PREAMBLE_LEN(PRE), .IPG_CYCLES(IPG)) dut (
        .GTX_CLK(GTX_CLK), .mr_main_reset(mr_main_reset),
        .code_sync_status(code_sync_status), .transmitting(transmitting),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .valid0(valid0), .valid1(valid1), .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1), .ready0(ready0), .ready1(ready1),
        .TXD(TXD), .TX_EN(TX_EN), .TX_ER(TX_ER), .busy(busy)
    );

    initial GTX_CLK = 1'b0;
    always #5 GTX_CLK = ~GTX_CLK;

    int checks;
    int errors;

    // expected stream: {TX_ER, TXD} per TX_EN cycle, plus per-frame length/owner/kind
    logic [8:0] exp_byte_q[$];
    int         exp_len_q[$];
    int         exp_own_q[$];
    bit         exp_norm_q[$];

    // per-requester frame plan consumed by the drivers
    logic [7:0] plan_bytes[2][8];
    int         plan_len[2];
    int         plan_ur[2];
    int         plan_drain[2];
    bit         plan_act[2];
    int         model_last;

    bit sb_on;
    bit noise_on;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int plan_total(input int n);
        return (plan_ur[n] < 0) ? plan_len[n] : plan_ur[n] + 1 + plan_drain[n];
    endfunction

    function automatic logic [9:0] plan_item(input int n, input int idx);
        int j;
        if (plan_ur[n] < 0) return {1'b1, idx == plan_len[n] - 1, plan_bytes[n][idx]};
        if (idx < plan_ur[n]) return {2'b10, plan_bytes[n][idx]};
        if (idx == plan_ur[n]) return 10'h000;
        j = idx - plan_ur[n] - 1;
        return {1'b1, j == plan_drain[n] - 1, 8'(8'hE0 + j)};
    endfunction

    task automatic gen_plan(input int n, input bit allow_ur);
        plan_len[n] = $urandom_range(1, 8);
        for (int i = 0; i < 8; i++) plan_bytes[n][i] = 8'($urandom);
        plan_ur[n] = -1;
        if (allow_ur && $urandom_range(0, 3) == 0) plan_ur[n] = $urandom_range(0, plan_len[n] - 1);
        plan_drain[n] = $urandom_range(1, 3);
    endtask

    // frame as seen on the wire: preamble, SFD, payload, or the payload prefix + error byte
    task automatic push_expect(input int n);
        bit normal;
        int nbytes;
        normal = (plan_ur[n] < 0);
        nbytes = normal ? plan_len[n] : plan_ur[n];
        exp_len_q.push_back(PRE + 1 + nbytes + (normal ? 0 : 1));
        exp_own_q.push_back(n);
        exp_norm_q.push_back(normal);
        for (int i = 0; i < PRE; i++) exp_byte_q.push_back(9'h055);
        exp_byte_q.push_back(9'h0D5);
        for (int i = 0; i < nbytes; i++) exp_byte_q.push_back({1'b0, plan_bytes[n][i]});
        if (!normal) exp_byte_q.push_back(9'h100);
    endtask

    task automatic set_req(input int n, input logic r);
        if (n == 0) req0 = r; else req1 = r;
    endtask

    task automatic set_in(input int n, input logic v, input logic l, input logic [7:0] d);
        if (n == 0) begin valid0 = v; last0 = l; data0 = d; end
        else begin valid1 = v; last1 = l; data1 = d; end
    endtask

    function automatic logic gnt_of(input int n);
        return (n == 0) ? gnt0 : gnt1;
    endfunction

    function automatic logic ready_of(input int n);
        return (n == 0) ? ready0 : ready1;
    endfunction

    task automatic drive(input int n);
        int t;
        int idx;
        int total;
        logic [9:0] it;
        if (!plan_act[n]) return;
        total = plan_total(n);
        set_req(n, 1'b1);
        t = 0;
        while (!gnt_of(n) && t < 300) begin
            @(negedge GTX_CLK);
            t++;
        end
        set_req(n, 1'b0);
        if (!gnt_of(n)) begin
            check_eq("grant_timeout", gnt_of(n), 1);
            return;
        end
        idx = 0;
        t = 0;
        while (idx < total && t < 200) begin
            if (ready_of(n)) begin
                it = plan_item(n, idx);
                set_in(n, it[9], it[8], it[7:0]);
                idx++;
            end else begin
                set_in(n, 1'b0, 1'b0, 8'h00);
            end
            @(negedge GTX_CLK);
            t++;
        end
        set_in(n, 1'b0, 1'b0, 8'h00);
        if (idx < total) check_eq("data_timeout", idx, total);
    endtask

    task automatic finish_round();
        int t;
        t = 0;
        while (busy && t < 100) begin
            @(negedge GTX_CLK);
            t++;
        end
        check_eq("idle_timeout", busy, 0);
        repeat ($urandom_range(1, 3)) @(negedge GTX_CLK);
    endtask

    task automatic do_round(input bit r0, input bit r1);
        int first;
        plan_act[0] = r0;
        plan_act[1] = r1;
        if (r0 && r1) begin
            first = (model_last == 1) ? 0 : 1;
            push_expect(first);
            push_expect(1 - first);
            model_last = 1 - first;
        end else if (r0) begin
            push_expect(0);
            model_last = 0;
        end else begin
            push_expect(1);
            model_last = 1;
        end
        fork
            drive(0);
            drive(1);
        join
        finish_round();
    endtask

    task automatic do_blocked();
        gen_plan(1, 1'b0);
        plan_act[0] = 1'b0;
        plan_act[1] = 1'b1;
        code_sync_status = 1'b0;
        transmitting = 1'b0;
        push_expect(1);
        model_last = 1;
        fork
            drive(1);
            begin
                repeat (20) begin
                    @(negedge GTX_CLK);
                    check_eq("nosync_gnt1", gnt1, 0);
                    check_eq("nosync_txen", TX_EN, 0);
                end
                code_sync_status = 1'b1;
                transmitting = 1'b1;
                repeat (20) begin
                    @(negedge GTX_CLK);
                    check_eq("pcsbusy_gnt1", gnt1, 0);
                    check_eq("pcsbusy_txen", TX_EN, 0);
                end
                transmitting = 1'b0;
                @(negedge GTX_CLK);
                check_eq("release_gnt1", gnt1, 1);
                check_eq("release_txen", TX_EN, 1);
            end
        join
        finish_round();
    endtask

    // line noise on sync/transmitting while a frame is in flight must not matter
    initial begin
        forever begin
            @(negedge GTX_CLK);
            if (noise_on) begin
                if (busy) begin
                    code_sync_status = 1'($urandom_range(0, 1));
                    transmitting = 1'($urandom_range(0, 1));
                end else begin
                    code_sync_status = 1'b1;
                    transmitting = 1'b0;
                end
            end
        end
    end

    bit         prev_en;
    bit         in_frame;
    bit         counting;
    bit         cur_normal;
    int         cur_len;
    int         seen;
    int         ipg_cnt;
    logic [8:0] e;

    always @(negedge GTX_CLK) begin
        if (!mr_main_reset) begin
            prev_en  = 1'b0;
            in_frame = 1'b0;
            counting = 1'b0;
        end else begin
            check_eq("one_hot_gnt", gnt0 & gnt1, 0);
            check_eq("ready0_owner", ready0 & ~gnt0, 0);
            check_eq("ready1_owner", ready1 & ~gnt1, 0);
            if (!TX_EN) check_eq("er_without_en", TX_ER, 0);
            if (!busy) check_eq("idle_outputs", {gnt1, gnt0, TX_ER, TX_EN, TXD}, 0);
            if (sb_on) begin
                if (TX_EN && !prev_en) begin
                    if (exp_len_q.size() == 0) begin
                        check_eq("unexpected_frame", exp_len_q.size(), 1);
                    end else begin
                        cur_len    = exp_len_q.pop_front();
                        cur_normal = exp_norm_q.pop_front();
                        check_eq("frame_owner", {gnt1, gnt0}, (exp_own_q.pop_front() == 1) ? 2'b10 : 2'b01);
                        seen     = 0;
                        in_frame = 1'b1;
                    end
                end
                if (TX_EN) begin
                    seen++;
                    if (exp_byte_q.size() == 0) begin
                        check_eq("extra_tx_byte", {TX_ER, TXD}, 9'h1FF);
                    end else begin
                        e = exp_byte_q.pop_front();
                        check_eq("txd_er", {TX_ER, TXD}, e);
                    end
                end
                if (!TX_EN && prev_en && in_frame) begin
                    check_eq("frame_len", seen, cur_len);
                    in_frame = 1'b0;
                    if (cur_normal) begin
                        counting = 1'b1;
                        ipg_cnt  = 0;
                    end
                end
                if (counting) begin
                    if (busy && !TX_EN) begin
                        ipg_cnt++;
                    end else if (!busy) begin
                        check_eq("ipg_len", ipg_cnt, IPG);
                        counting = 1'b0;
                    end
                end
            end
            prev_en = TX_EN;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int en_cnt;
        int pattern;
        checks = 0;
        errors = 0;
        sb_on = 1'b0;
        noise_on = 1'b0;
        model_last = 1;
        mr_main_reset = 1'b0;
        code_sync_status = 1'b1;
        transmitting = 1'b0;
        req0 = 1'b1;
        req1 = 1'b1;
        data0 = 8'h00; data1 = 8'h00;
        valid0 = 1'b1; valid1 = 1'b1;
        last0 = 1'b0; last1 = 1'b0;

        repeat (2) @(negedge GTX_CLK);
        check_eq("rst_txd", TXD, 0);
        check_eq("rst_en_er", {TX_EN, TX_ER}, 0);
        check_eq("rst_gnt", {gnt1, gnt0}, 0);
        check_eq("rst_ready", {ready1, ready0}, 0);
        check_eq("rst_busy", busy, 0);
        req0 = 1'b0; req1 = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
        mr_main_reset = 1'b1;
        sb_on = 1'b1;
        @(negedge GTX_CLK);

        // basic 4-byte frame from requester 0
        plan_len[0] = 4;
        plan_bytes[0][0] = 8'hA1; plan_bytes[0][1] = 8'hA2;
        plan_bytes[0][2] = 8'hA3; plan_bytes[0][3] = 8'hA4;
        plan_ur[0] = -1;
        plan_drain[0] = 1;
        do_round(1'b1, 1'b0);

        // simultaneous requests twice: the order flips on the second pair
        gen_plan(0, 1'b0); gen_plan(1, 1'b0);
        do_round(1'b1, 1'b1);
        gen_plan(0, 1'b0); gen_plan(1, 1'b0);
        do_round(1'b1, 1'b1);

        // underrun after byte 2 of 5
        gen_plan(0, 1'b0);
        plan_len[0] = 5;
        plan_ur[0] = 2;
        plan_drain[0] = 3;
        do_round(1'b1, 1'b0);

        do_blocked();

        noise_on = 1'b1;
        for (int i = 0; i < 24; i++) begin
            pattern = $urandom_range(1, 3);
            gen_plan(0, 1'b1);
            gen_plan(1, 1'b1);
            do_round(pattern[0], pattern[1]);
        end
        noise_on = 1'b0;
        @(negedge GTX_CLK);
        code_sync_status = 1'b1;
        transmitting = 1'b0;

        // asynchronous reset in the middle of the data phase
        sb_on = 1'b0;
        req0 = 1'b1;
        t = 0;
        while (!gnt0 && t < 50) begin
            @(negedge GTX_CLK);
            t++;
        end
        req0 = 1'b0;
        check_eq("rst_test_gnt", gnt0, 1);
        en_cnt = 0;
        t = 0;
        while (en_cnt < PRE + 4 && t < 60) begin
            if (ready0) begin
                valid0 = 1'b1;
                last0 = 1'b0;
                data0 = 8'($urandom);
            end
            if (TX_EN) en_cnt++;
            @(negedge GTX_CLK);
            t++;
        end
        check_eq("rst_test_in_data", TX_EN, 1);
        #2;
        mr_main_reset = 1'b0;
        #1;
        check_eq("async_rst_en", TX_EN, 0);
        check_eq("async_rst_gnt", {gnt1, gnt0}, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_ready", ready0, 0);
        valid0 = 1'b0;
        repeat (3) begin
            @(negedge GTX_CLK);
            check_eq("held_rst_en", TX_EN, 0);
        end
        mr_main_reset = 1'b1;
        exp_byte_q.delete();
        exp_len_q.delete();
        exp_own_q.delete();
        exp_norm_q.delete();
        model_last = 1;
        sb_on = 1'b1;
        @(negedge GTX_CLK);

        gen_plan(0, 1'b0);
        do_round(1'b1, 1'b0);
        model_last = 1;
        mr_main_reset = 1'b0;
        @(negedge GTX_CLK);
        mr_main_reset = 1'b1;
        @(negedge GTX_CLK);
        gen_plan(0, 1'b1); gen_plan(1, 1'b1);
        do_round(1'b1, 1'b1);

        check_eq("exp_bytes_left", exp_byte_q.size(), 0);
        check_eq("exp_frames_left", exp_len_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
